// File: rtl/tank_pkg.sv
// tank_pkg: shared definitions for the tank game map logic.
//   - tile_t tile codes, FSM state encoding for map_state
//   - map geometry (MAP_COLS x MAP_ROWS tiles of 2**TILE_SHIFT pixels)
//   - BASE_HP, selected by the optional macro BASE_HP_MULTI_EN
//     (defined: 3 hits per base, undefined: 1 hit per base)
//   - winner encodings
//   - helpers mapping a pixel coordinate to a tile address / range check
package tank_pkg;

    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int TILE_SHIFT = 5;
    localparam int MAP_TILES  = MAP_COLS * MAP_ROWS;

    localparam logic [9:0] MAP_W_PX = 10'(MAP_COLS << TILE_SHIFT);
    localparam logic [9:0] MAP_H_PX = 10'(MAP_ROWS << TILE_SHIFT);

`ifdef BASE_HP_MULTI_EN
    localparam logic [1:0] BASE_HP = 2'd3;
`else
    localparam logic [1:0] BASE_HP = 2'd1;
`endif

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [2:0] {
        TILE_EMPTY = 3'd0,
        TILE_HARD  = 3'd1,
        TILE_SOFT  = 3'd2,
        TILE_BASE1 = 3'd3,
        TILE_BASE2 = 3'd4
    } tile_t;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_CHECK1 = 3'd2,
        ST_CHECK2 = 3'd3,
        ST_OVER   = 3'd4
    } map_fsm_t;

    // Linear tile address row*20 + col; row*20 built as row*16 + row*4.
    function automatic logic [8:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
        logic [8:0] row;
        logic [8:0] col;
        row = 9'(y >> TILE_SHIFT);
        col = 9'(x >> TILE_SHIFT);
        return (row << 4) + (row << 2) + col;
    endfunction

    // True when the pixel lies inside the 640x480 playfield.
    function automatic logic coord_in_map(input logic [9:0] x, input logic [9:0] y);
        return (x < MAP_W_PX) && (y < MAP_H_PX);
    endfunction

endpackage

// File: rtl/map_rom.sv
// map_rom: pristine 20x15 tank-game layout, combinational lookup.
//   addr : in  9  linear tile address (row*20 + col), 0..299
//   tile : out 3  tile_t code at addr (TILE_EMPTY for addr >= 300)
// Layout: hard-wall border, P2 base at (col 10,row 1) next to a soft wall
// at col 9, P1 base at (col 9,row 13) next to a soft wall at col 10,
// soft walls at row 3 cols 1 and 18, and a row-7 barrier (soft, with a
// hard core at cols 9..10).
module map_rom
    import tank_pkg::*;
(
    input  logic [8:0] addr,
    output logic [2:0] tile
);

    logic [8:0] row_s;
    logic [8:0] col_s;
    tile_t      tile_s;

    // Split the address back into row/col and classify the tile.
    always_comb begin
        row_s  = addr / 9'(MAP_COLS);
        col_s  = addr - (row_s * 9'(MAP_COLS));
        tile_s = TILE_EMPTY;
        if (addr >= 9'(MAP_TILES)) begin
            tile_s = TILE_EMPTY;
        end else if ((row_s == 9'd0) || (row_s == 9'(MAP_ROWS - 1)) ||
                     (col_s == 9'd0) || (col_s == 9'(MAP_COLS - 1))) begin
            tile_s = TILE_HARD;
        end else if ((row_s == 9'd1) && (col_s == 9'd9)) begin
            tile_s = TILE_SOFT;
        end else if ((row_s == 9'd1) && (col_s == 9'd10)) begin
            tile_s = TILE_BASE2;
        end else if ((row_s == 9'd13) && (col_s == 9'd9)) begin
            tile_s = TILE_BASE1;
        end else if ((row_s == 9'd13) && (col_s == 9'd10)) begin
            tile_s = TILE_SOFT;
        end else if ((row_s == 9'd3) && ((col_s == 9'd1) || (col_s == 9'd18))) begin
            tile_s = TILE_SOFT;
        end else if ((row_s == 9'd7) && (col_s >= 9'd4) && (col_s <= 9'd15)) begin
            if ((col_s == 9'd9) || (col_s == 9'd10)) begin
                tile_s = TILE_HARD;
            end else begin
                tile_s = TILE_SOFT;
            end
        end else begin
            tile_s = TILE_EMPTY;
        end
    end

    assign tile = tile_s;

endmodule

// File: rtl/map_state.sv
// map_state: live 20x15 tile map of the tank game.
//   Loads the layout from map_rom (INIT, 300 cycles), then on every frame
//   edge checks bullet 1 (CHECK1) and bullet 2 (CHECK2) against the map,
//   destroying soft walls, counting base hits and declaring a winner.
// Optional macro BASE_HP_MULTI_EN (via tank_pkg): bases take 3 hits, else 1.
// Ports:
//   Clk, Reset            : system clock, async active-high reset
//   frame_clk             : slow frame clock, rising edge starts a check pass
//   restart               : in OVER, reloads the map and resumes play
//   bulN_x/y/active       : bullet pixel position and in-flight flag
//   rd_x, rd_y / rd_tile  : pixel read port, tile returned one cycle later
//   bul1_hit, bul2_hit    : bullet stopped this frame (held to next edge)
//   game_over, winner     : end of game, 01 player 1 / 10 player 2
//   ready                 : map loaded
//   base1_hp, base2_hp    : remaining base hits
module map_state
    import tank_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] bul1_x,
    input  logic [9:0] bul1_y,
    input  logic       bul1_active,
    input  logic [9:0] bul2_x,
    input  logic [9:0] bul2_y,
    input  logic       bul2_active,
    input  logic [9:0] rd_x,
    input  logic [9:0] rd_y,
    output logic [2:0] rd_tile,
    output logic       bul1_hit,
    output logic       bul2_hit,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       ready,
    output logic [1:0] base1_hp,
    output logic [1:0] base2_hp
);

    logic [2:0] tiles_r [0:MAP_TILES-1];

    map_fsm_t   state_r, state_n;
    logic [8:0] init_addr_r, init_addr_n;
    logic       ready_r, ready_n;
    logic       game_over_r, game_over_n;
    logic [1:0] winner_r, winner_n;
    logic [1:0] hp1_r, hp1_n;
    logic [1:0] hp2_r, hp2_n;
    logic       hit1_r, hit1_n;
    logic       hit2_r, hit2_n;

    logic [1:0] frame_sync_r;
    logic       frame_prev_r;
    logic       frame_rise_s;

    logic [2:0] rom_tile_s;
    logic       wr_en_s;
    logic [8:0] wr_addr_s;
    logic [2:0] wr_data_s;

    logic [9:0] chk_x_s, chk_y_s;
    logic       chk_act_s;
    logic       chk_valid_s;
    logic [8:0] chk_addr_s;
    tile_t      chk_tile_s;
    logic       chk_hit_s;

    logic       rd_valid_s;
    logic [8:0] rd_addr_s;
    logic [2:0] rd_tile_r;

    map_rom u_map_rom (
        .addr (init_addr_r),
        .tile (rom_tile_s)
    );

    assign frame_rise_s = frame_sync_r[1] & ~frame_prev_r;

    // Select the bullet under test for the current check state and fetch its tile.
    always_comb begin
        if (state_r == ST_CHECK2) begin
            chk_x_s   = bul2_x;
            chk_y_s   = bul2_y;
            chk_act_s = bul2_active;
        end else begin
            chk_x_s   = bul1_x;
            chk_y_s   = bul1_y;
            chk_act_s = bul1_active;
        end
        chk_valid_s = chk_act_s && coord_in_map(chk_x_s, chk_y_s);
        chk_addr_s  = tile_addr(chk_x_s, chk_y_s);
        if (chk_valid_s) begin
            chk_tile_s = tile_t'(tiles_r[chk_addr_s]);
        end else begin
            chk_tile_s = TILE_EMPTY;
        end
    end

    // Next-state logic: map loading, bullet resolution, game-over bookkeeping.
    always_comb begin
        state_n     = state_r;
        init_addr_n = init_addr_r;
        ready_n     = ready_r;
        game_over_n = game_over_r;
        winner_n    = winner_r;
        hp1_n       = hp1_r;
        hp2_n       = hp2_r;
        hit1_n      = hit1_r;
        hit2_n      = hit2_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = 9'd0;
        wr_data_s   = TILE_EMPTY;
        chk_hit_s   = 1'b0;

        case (state_r)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_addr_s = init_addr_r;
                wr_data_s = rom_tile_s;
                if (init_addr_r == 9'(MAP_TILES - 1)) begin
                    init_addr_n = 9'd0;
                    ready_n     = 1'b1;
                    state_n     = ST_RUN;
                end else begin
                    init_addr_n = init_addr_r + 9'd1;
                end
            end

            ST_RUN: begin
                if (frame_rise_s) begin
                    hit1_n  = 1'b0;
                    hit2_n  = 1'b0;
                    state_n = ST_CHECK1;
                end else begin
                    state_n = ST_RUN;
                end
            end

            ST_CHECK1, ST_CHECK2: begin
                case (chk_tile_s)
                    TILE_HARD: begin
                        chk_hit_s = 1'b1;
                    end
                    TILE_SOFT: begin
                        chk_hit_s = 1'b1;
                        wr_en_s   = 1'b1;
                        wr_addr_s = chk_addr_s;
                        wr_data_s = TILE_EMPTY;
                    end
                    TILE_BASE1: begin
                        chk_hit_s = 1'b1;
                        if (hp1_r != 2'd0) begin
                            hp1_n = hp1_r - 2'd1;
                            // Base destroyed: clear the tile; only the first kill names a winner.
                            if (hp1_r == 2'd1) begin
                                wr_en_s   = 1'b1;
                                wr_addr_s = chk_addr_s;
                                wr_data_s = TILE_EMPTY;
                                if (!game_over_r) begin
                                    game_over_n = 1'b1;
                                    winner_n    = WIN_P2;
                                end else begin
                                    winner_n    = winner_r;
                                end
                            end else begin
                                wr_en_s = 1'b0;
                            end
                        end else begin
                            hp1_n = hp1_r;
                        end
                    end
                    TILE_BASE2: begin
                        chk_hit_s = 1'b1;
                        if (hp2_r != 2'd0) begin
                            hp2_n = hp2_r - 2'd1;
                            if (hp2_r == 2'd1) begin
                                wr_en_s   = 1'b1;
                                wr_addr_s = chk_addr_s;
                                wr_data_s = TILE_EMPTY;
                                if (!game_over_r) begin
                                    game_over_n = 1'b1;
                                    winner_n    = WIN_P1;
                                end else begin
                                    winner_n    = winner_r;
                                end
                            end else begin
                                wr_en_s = 1'b0;
                            end
                        end else begin
                            hp2_n = hp2_r;
                        end
                    end
                    default: begin
                        chk_hit_s = 1'b0;
                    end
                endcase

                if (state_r == ST_CHECK1) begin
                    hit1_n  = chk_hit_s;
                    state_n = ST_CHECK2;
                end else begin
                    hit2_n  = chk_hit_s;
                    state_n = game_over_n ? ST_OVER : ST_RUN;
                end
            end

            ST_OVER: begin
                hit1_n = 1'b0;
                hit2_n = 1'b0;
                if (restart) begin
                    state_n     = ST_INIT;
                    init_addr_n = 9'd0;
                    ready_n     = 1'b0;
                    game_over_n = 1'b0;
                    winner_n    = WIN_NONE;
                    hp1_n       = BASE_HP;
                    hp2_n       = BASE_HP;
                end else begin
                    state_n     = ST_OVER;
                end
            end

            default: begin
                state_n     = ST_INIT;
                init_addr_n = 9'd0;
                ready_n     = 1'b0;
            end
        endcase
    end

    // Control registers and frame-clock synchronizer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_INIT;
            init_addr_r  <= 9'd0;
            ready_r      <= 1'b0;
            game_over_r  <= 1'b0;
            winner_r     <= WIN_NONE;
            hp1_r        <= BASE_HP;
            hp2_r        <= BASE_HP;
            hit1_r       <= 1'b0;
            hit2_r       <= 1'b0;
            frame_sync_r <= 2'b00;
            frame_prev_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            init_addr_r  <= init_addr_n;
            ready_r      <= ready_n;
            game_over_r  <= game_over_n;
            winner_r     <= winner_n;
            hp1_r        <= hp1_n;
            hp2_r        <= hp2_n;
            hit1_r       <= hit1_n;
            hit2_r       <= hit2_n;
            frame_sync_r <= {frame_sync_r[0], frame_clk};
            frame_prev_r <= frame_sync_r[1];
        end
    end

    // Tile storage; contents are rebuilt by INIT after every reset, so no reset here.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            tiles_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Read-port address decode; off-map pixels read as empty.
    always_comb begin
        rd_valid_s = coord_in_map(rd_x, rd_y);
        rd_addr_s  = tile_addr(rd_x, rd_y);
    end

    // Registered tile read for the color mapper.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_tile_r <= 3'd0;
        end else if (rd_valid_s) begin
            rd_tile_r <= tiles_r[rd_addr_s];
        end else begin
            rd_tile_r <= 3'd0;
        end
    end

    assign rd_tile   = rd_tile_r;
    assign bul1_hit  = hit1_r;
    assign bul2_hit  = hit2_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;
    assign ready     = ready_r;
    assign base1_hp  = hp1_r;
    assign base2_hp  = hp2_r;

endmodule
